// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multi-cycle CPU control unit. Each instruction runs through FETCH, DECODE,
// EXECUTE, MEM and WRITE_BACK. The unit drives the IR load, PC, register-file,
// ALU and memory strobes. It also supports variable-latency memory with a
// timeout into FAULT, a global stall, and illegal-opcode reporting.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH   0  | wait for instr_valid, latch IR
// DECODE  1  | retire JMP / illegal opcodes, otherwise go to EXECUTE
// EXECUTE 2  | ALU op, address generation for LD/ST, branch resolve+retire
// MEM     3  | wait for mem_ready, count wait cycles, retire ST
// WB      4  | register write, retire ALU ops and LD
// FAULT   5  | memory timeout; absorbing until reset
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instr_valid       opcode carries a valid instruction
//   opcode [OPW]      opcode of the fetched instruction
//   stall             freeze sequencing and gate side-effect strobes
//   mem_ready         data memory finished the current access
//   zero              ALU zero flag, used to resolve BEQ/BNE
//   ir_load, pc_en, pc_src[2], reg_write, mem_read, mem_write, alu_src,
//   result_sel, alu_ctrl[ALUW]   datapath control
//   state_o[3]        current state encoding
//   instr_done        one-cycle retire pulse
//   illegal_op        one-cycle pulse in DECODE for opcodes above 9
//   fault             high while in FAULT
module mc_control_fsm #(
    parameter int OPW     = 4,
    parameter int ALUW    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [OPW-1:0]  opcode,
    input  logic            stall,
    input  logic            mem_ready,
    input  logic            zero,
    output logic            ir_load,
    output logic            pc_en,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            result_sel,
    output logic [ALUW-1:0] alu_ctrl,
    output logic [2:0]      state_o,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM        = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    // A zero-width counter is not legal, so keep one bit when the timeout is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LD  = OPW'(5);
    localparam logic [OPW-1:0] OP_ST  = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(8);
    localparam logic [OPW-1:0] OP_BNE = OPW'(9);

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_CMP = ALUW'(6);

    state_t          state_q, state_d;
    logic [OPW-1:0]  ir_q, ir_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic is_alu, is_ld, is_st, is_jmp, is_branch, is_illegal, taken, go;

    assign is_alu     = (ir_q <= OP_XOR);
    assign is_ld      = (ir_q == OP_LD);
    assign is_st      = (ir_q == OP_ST);
    assign is_jmp     = (ir_q == OP_JMP);
    assign is_branch  = (ir_q == OP_BEQ) || (ir_q == OP_BNE);
    assign is_illegal = (ir_q > OP_BNE);
    assign taken      = (ir_q == OP_BEQ) ? zero : ~zero;
    assign go         = ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Side-effect strobes are qualified with go; mux-style selects (pc_src,
    // alu_src, alu_ctrl, mem_read, result_sel) keep their state value under stall.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        result_sel = 1'b0;
        alu_ctrl   = '0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        fault      = 1'b0;
        state_o    = state_q;

        case (state_q)
            S_FETCH: begin
                if (instr_valid && go) begin
                    ir_load = 1'b1;
                    ir_d    = opcode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    illegal_op = go;
                    pc_en      = go;
                    instr_done = go;
                    if (go) state_d = S_FETCH;
                end else if (is_jmp) begin
                    pc_en      = go;
                    pc_src     = 2'b10;
                    instr_done = go;
                    if (go) state_d = S_FETCH;
                end else if (go) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    // ADD..XOR map onto consecutive ALU codes starting at 001.
                    alu_ctrl = ALUW'(ir_q) + ALUW'(1);
                    if (go) state_d = S_WRITE_BACK;
                end else if (is_ld || is_st) begin
                    alu_src  = 1'b1;
                    alu_ctrl = ALU_ADD;
                    if (go) begin
                        cnt_d   = '0;
                        state_d = S_MEM;
                    end
                end else begin
                    alu_ctrl   = is_branch ? ALU_CMP : '0;
                    pc_en      = go & is_branch;
                    pc_src     = (is_branch && taken) ? 2'b01 : 2'b00;
                    instr_done = go & is_branch;
                    if (go) state_d = S_FETCH;
                end
            end
            S_MEM: begin
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
                mem_read  = is_ld;
                mem_write = go & ~is_ld;
                if (go) begin
                    // A ready on the final allowed cycle wins over the timeout.
                    if (mem_ready) begin
                        if (is_ld) begin
                            state_d = S_WRITE_BACK;
                        end else begin
                            pc_en      = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) state_d = S_FAULT;
                    end
                end
            end
            S_WRITE_BACK: begin
                reg_write  = go;
                result_sel = is_ld;
                pc_en      = go;
                instr_done = go;
                if (go) state_d = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Outputs read as all-zero while reset is held, even if instr_valid is high.
        if (reset) begin
            ir_load    = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            result_sel = 1'b0;
            alu_ctrl   = '0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            fault      = 1'b0;
            state_o    = 3'd0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm. Each instruction is expanded into the
// expected per-cycle output trace using the latency table and the strobe
// list of each phase. Stall cycles are then inserted as gated copies of
// the cycle they freeze.
module tb_mc_control_fsm;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic       stall = 1'b0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       ir_load, pc_en, reg_write, mem_read, mem_write, alu_src, result_sel;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl, state_o;
    logic       instr_done, illegal_op, fault;

    int checks = 0;
    int errors = 0;

    mc_control_fsm #(.OPW(4), .ALUW(3), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .stall(stall), .mem_ready(mem_ready), .zero(zero),
        .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
        .result_sel(result_sel), .alu_ctrl(alu_ctrl), .state_o(state_o),
        .instr_done(instr_done), .illegal_op(illegal_op), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {ir_load, pc_en, pc_src, reg_write, mem_read, mem_write, alu_src,
                  result_sel, alu_ctrl, state_o, instr_done, illegal_op, fault};

    typedef struct {
        logic [17:0] v;
        logic        mrdy;
        logic        fetch;
    } rec_t;

    rec_t q[$];

    function automatic logic [17:0] mk(input logic [2:0] st, input logic irl,
                                       input logic pe, input logic [1:0] ps,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic as, input logic rs,
                                       input logic [2:0] ac, input logic dn,
                                       input logic ill, input logic ft);
        return {irl, pe, ps, rw, mr, mw, as, rs, ac, st, dn, ill, ft};
    endfunction

    // Under stall only side-effect strobes drop; selects and state stay visible.
    function automatic logic [17:0] stalled(input logic [17:0] v);
        return v & mk(3'd7, 0, 0, 2'd3, 0, 1, 0, 1, 1, 3'd7, 0, 0, 1);
    endfunction

    task automatic push(input logic [17:0] v, input logic mrdy, input logic fetch);
        rec_t r;
        r.v = v; r.mrdy = mrdy; r.fetch = fetch;
        q.push_back(r);
    endtask

    task automatic build(input int op, input int waits, input logic z);
        logic ld;
        logic tk;
        q.delete();
        push(mk(3'd0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0), 1'b0, 1'b1);
        if (op > 9) begin
            push(mk(3'd1, 0, 1, 2'd0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 0), 1'b0, 1'b0);
        end else if (op == 7) begin
            push(mk(3'd1, 0, 1, 2'd2, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0), 1'b0, 1'b0);
        end else begin
            push(mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0), 1'b0, 1'b0);
            if (op <= 4) begin
                push(mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'(op + 1), 0, 0, 0), 1'b0, 1'b0);
                push(mk(3'd4, 0, 1, 2'd0, 1, 0, 0, 0, 0, 3'd0, 1, 0, 0), 1'b0, 1'b0);
            end else if (op >= 8) begin
                tk = (op == 8) ? z : ~z;
                push(mk(3'd2, 0, 1, tk ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 3'd6, 1, 0, 0),
                     1'b0, 1'b0);
            end else begin
                ld = (op == 5);
                push(mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 1, 0, 3'd1, 0, 0, 0), 1'b0, 1'b0);
                for (int i = 0; i < 1000; i++) begin
                    if (i == waits) begin
                        push(mk(3'd3, 0, ~ld, 2'd0, 0, ld, ~ld, 1, 0, 3'd1, ~ld, 0, 0),
                             1'b1, 1'b0);
                        if (ld)
                            push(mk(3'd4, 0, 1, 2'd0, 1, 0, 0, 0, 1, 3'd0, 1, 0, 0),
                                 1'b0, 1'b0);
                        break;
                    end
                    push(mk(3'd3, 0, 0, 2'd0, 0, ld, ~ld, 1, 0, 3'd1, 0, 0, 0), 1'b0, 1'b0);
                    if (i == TO - 1) begin
                        repeat (3) push(mk(3'd5, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1),
                                        1'b0, 1'b0);
                        break;
                    end
                end
            end
        end
    endtask

    // Entered and left on a falling edge; inputs are driven there, outputs
    // are compared 1 time unit later, well away from the rising edge.
    task automatic run_instr(input string name, input int op, input int waits,
                             input logic z, input int stall_pct, input int stall_at,
                             input int stall_len, input int max_recs,
                             output int cycles, output int dones);
        logic [17:0] exp;
        build(op, waits, z);
        cycles = 0;
        dones  = 0;
        zero   = z;
        for (int k = 0; k < q.size() && k < max_recs; k++) begin
            int ns;
            ns = (k == stall_at) ? stall_len : 0;
            if ($urandom_range(99) < 32'(stall_pct)) ns += 1 + int'($urandom_range(1));
            for (int s = 0; s <= ns; s++) begin
                logic st;
                st = (s < ns);
                stall = st;
                mem_ready = st ? 1'($urandom_range(1)) : q[k].mrdy;
                if (q[k].fetch) begin
                    instr_valid = 1'b1;
                    opcode      = 4'(op);
                end else begin
                    instr_valid = 1'($urandom_range(1));
                    opcode      = 4'($urandom_range(15));
                end
                exp = st ? stalled(q[k].v) : q[k].v;
                #1;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s op=%0d cycle %0d: outputs got %h expected %h",
                             name, op, cycles, obs, exp);
                end
                cycles++;
                dones += int'(instr_done);
                @(negedge clk);
            end
        end
        stall       = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic do_reset(input string name);
        reset       = 1'b1;
        instr_valid = 1'b1;
        opcode      = 4'($urandom_range(15));
        mem_ready   = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL %s: outputs during reset got %h expected 0", name, obs);
        end
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset("reset");
    endtask

    task automatic test_alu();
        int c, d;
        run_instr("alu_add", 0, 0, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 4 || d !== 1) begin
            errors++;
            $display("FAIL alu_add_latency: cycles %0d dones %0d expected 4 and 1", c, d);
        end
    endtask

    task automatic test_load_wait();
        int c, d;
        run_instr("ld_wait", 5, 3, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 8 || d !== 1) begin
            errors++;
            $display("FAIL ld_wait_latency: cycles %0d dones %0d expected 8 and 1", c, d);
        end
    endtask

    task automatic test_branches();
        int c, d;
        run_instr("beq_taken", 8, 0, 1'b1, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 3 || d !== 1) begin
            errors++;
            $display("FAIL beq_latency: cycles %0d dones %0d expected 3 and 1", c, d);
        end
        run_instr("bne_not_taken", 9, 0, 1'b1, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 3 || d !== 1) begin
            errors++;
            $display("FAIL bne_latency: cycles %0d dones %0d expected 3 and 1", c, d);
        end
        run_instr("jmp", 7, 0, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 2 || d !== 1) begin
            errors++;
            $display("FAIL jmp_latency: cycles %0d dones %0d expected 2 and 1", c, d);
        end
    endtask

    task automatic test_timeout();
        int c, d;
        run_instr("st_timeout", 6, 999, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (d !== 0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL st_timeout_fault: dones %0d fault %b expected 0 and 1", d, fault);
        end
        do_reset("fault_reset");
        run_instr("st_last_ready", 6, TO - 1, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 4 + TO - 1 || d !== 1) begin
            errors++;
            $display("FAIL st_last_ready: cycles %0d dones %0d expected %0d and 1",
                     c, d, 4 + TO - 1);
        end
    endtask

    task automatic test_stall_illegal();
        int c, d;
        run_instr("sub_stall", 1, 0, 1'b0, 0, 2, 3, 99, c, d);
        checks++;
        if (c !== 7 || d !== 1) begin
            errors++;
            $display("FAIL sub_stall_latency: cycles %0d dones %0d expected 7 and 1", c, d);
        end
        run_instr("illegal12", 12, 0, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 2 || d !== 1) begin
            errors++;
            $display("FAIL illegal_latency: cycles %0d dones %0d expected 2 and 1", c, d);
        end
    endtask

    task automatic test_mid_reset();
        int c, d;
        run_instr("mid_reset_ld", 5, 5, 1'b0, 0, -1, 0, 4, c, d);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0 || d !== 0) begin
            errors++;
            $display("FAIL mid_reset: outputs %h dones %0d expected 0 and 0", obs, d);
        end
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        run_instr("after_reset_add", 0, 0, 1'b0, 0, -1, 0, 99, c, d);
        checks++;
        if (c !== 4 || d !== 1) begin
            errors++;
            $display("FAIL after_reset_add: cycles %0d dones %0d expected 4 and 1", c, d);
        end
    endtask

    task automatic test_random();
        int c, d, op;
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++) begin
                stall       = 1'($urandom_range(1));
                instr_valid = 1'b0;
                mem_ready   = 1'($urandom_range(1));
                #1;
                checks++;
                if (obs !== 18'd0) begin
                    errors++;
                    $display("FAIL idle_fetch: outputs got %h expected 0", obs);
                end
                @(negedge clk);
            end
            stall = 1'b0;
            op = int'($urandom_range(15));
            run_instr("random", op, int'($urandom_range(6)), 1'($urandom_range(1)),
                      25, -1, 0, 99, c, d);
            checks++;
            if (d !== 1) begin
                errors++;
                $display("FAIL random_retire op=%0d: dones %0d expected 1", op, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branches();
        test_timeout();
        do_reset("pre_stall_reset");
        test_stall_illegal();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multi-cycle control unit for the CPU datapath. It sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITE_BACK, and drives the register-file, ALU, memory and PC control strobes. Compared with the previous control FSM, it adds:
- an instruction-register load handshake,
- variable-latency memory with a timeout fault,
- a global stall,
- JMP support and resolved branch PC selection,
- illegal-opcode reporting.

## Interface
Parameters:
- OPW, 4, opcode width (≥4); opcode values above 9 are illegal
- ALUW, 3, ALU control width (≥3)
- TIMEOUT, 15, maximum MEM-state cycles waiting for mem_ready; 0 disables the timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word on opcode is valid
- opcode  in  OPW  opcode of the fetched instruction
- stall  in  1  freeze sequencing
- mem_ready  in  1  data memory has completed the current access
- zero  in  1  ALU zero flag
- ir_load  out  1  latch the instruction register
- pc_en  out  1  update the PC
- pc_src  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
- reg_write, mem_read, mem_write, alu_src, result_sel  out  1 each  datapath strobes
- alu_ctrl  out  ALUW  ALU operation
- state_o  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITE_BACK=4, FAULT=5
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is illegal
- fault  out  1  level; high while in FAULT

## Operation
Opcode map, with the alu_ctrl value used in EXECUTE:
- ADD 0 → 001, SUB 1 → 010, AND 2 → 011, OR 3 → 100, XOR 4 → 101
- LD 5, ST 6, JMP 7
- BEQ 8 and BNE 9 → 110 (compare)

Internal state:
- State register, IR (OPW bits) and memory wait counter (width $clog2(TIMEOUT+1)).
- All outputs are combinational from state, IR, zero, mem_ready and stall (Moore outputs plus stall gating).

State behaviour:
- **FETCH:** when instr_valid=1 and stall=0: ir_load=1, IR←opcode, go to DECODE. Otherwise remain in FETCH.
- **DECODE:** one cycle. Next state depends on IR:
  - Illegal opcode: illegal_op=1, pc_en=1, pc_src=00, instr_done=1, go to FETCH.
  - JMP: pc_en=1, pc_src=10, instr_done=1, go to FETCH.
  - All other opcodes: go to EXECUTE.
- **EXECUTE:** alu_ctrl is driven per the opcode map.
  - ALU ops: go to WRITE_BACK.
  - LD/ST: alu_src=1, alu_ctrl=001; clear the wait counter; go to MEM.
  - BEQ/BNE: pc_en=1. pc_src=01 if taken (BEQ: zero=1; BNE: zero=0), else 00. instr_done=1; go to FETCH.
- **MEM:** alu_src=1 and alu_ctrl=001 are held.
  - LD: mem_read=1. ST: mem_write=1.
  - mem_ready=1: LD goes to WRITE_BACK. ST asserts pc_en=1, pc_src=00, instr_done=1 and goes to FETCH.
  - mem_ready=0: the counter increments. If TIMEOUT≠0 and this is the TIMEOUT-th consecutive MEM cycle, go to FAULT.
  - mem_ready=1 on that same final cycle wins over the timeout.
- **WRITE_BACK:** reg_write=1; result_sel=1 for LD, 0 for ALU ops; pc_en=1, pc_src=00, instr_done=1; go to FETCH.
- **FAULT:** absorbing. All strobes are 0 and fault=1. Only reset exits this state.

Stall:
- With stall=1 in any state other than FAULT, the state, IR and counter hold.
- ir_load, pc_en, reg_write, mem_write, instr_done and illegal_op are forced to 0.
- mem_read, alu_src, alu_ctrl and pc_src keep their state values.
- mem_ready is ignored while stalled.

## Timing
Reset (asynchronous): state=FETCH, IR=0, counter=0. All outputs are 0, including fault and state_o.

Latency is counted from the FETCH cycle that accepts instr_valid, with no stall and mem_ready high on the first MEM cycle:

| Instruction | Cycles | Retiring state |
|---|---|---|
| JMP / illegal | 2 | DECODE |
| BEQ / BNE | 3 | EXECUTE |
| ALU ops | 4 | WRITE_BACK |
| ST | 4 | MEM |
| LD | 5 | WRITE_BACK |

- Each MEM cycle with mem_ready=0 adds one cycle.
- instr_done is high in exactly one cycle per instruction: its final cycle.
- reset asserted mid-instruction aborts it with no retire pulse. The next FETCH starts on the first clk edge after reset deasserts.
- A new instruction can be accepted in the cycle immediately after retirement.

## Test plan
- **Reset and ALU op:** pulse reset, then ADD with instr_valid held → state_o 0,1,2,4,0. alu_ctrl=001 in EXECUTE; reg_write=1, result_sel=0 and instr_done=1 in WRITE_BACK only.
- **Load with wait states:** LD with mem_ready low for 3 MEM cycles → mem_read high for 4 cycles; WRITE_BACK has result_sel=1, reg_write=1; 8 cycles total.
- **Branches:** BEQ with zero=1 → pc_src=01 in EXECUTE. BNE with zero=1 → pc_src=00. JMP → pc_src=10 in DECODE. Each produces exactly one instr_done.
- **Timeout:** ST with mem_ready stuck 0 and TIMEOUT=15 → FAULT after 15 MEM cycles, fault=1 and mem_write=0. Repeat with mem_ready=1 on the 15th cycle → retires, no fault. Reset clears fault.
- **Stall and illegal:** stall for 3 cycles in EXECUTE of SUB → state held, no strobes, then retires normally. Opcode 12 → illegal_op pulse, PC+1, back in FETCH.
- **Mid-instruction reset:** assert reset in MEM of LD → outputs 0 immediately, no instr_done, then a clean fetch.
